alu_scheduler: RTL and testbench

//  Shares one combinational alu instance between NREQ requesters (e.g. execute stage, branch-target adder, CSR unit).

---
 rtl/alu_scheduler.sv | 156 +++++++++++++++
 tb/tb_alu_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between NREQ requesters.
// Operands are registered at grant and the result is held per requester until accepted.
package alu_scheduler_pkg;
  localparam int WORD_W = 32;
  localparam int OP_W   = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;
endpackage

module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*OP_W-1:0]     req_op,
  input  logic [NREQ*WORD_W-1:0]   req_a,
  input  logic [NREQ*WORD_W-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready,
  output logic [WORD_W-1:0]        resp_out,
  output logic                     resp_zero,
  output logic                     resp_error,
  output logic [IDW-1:0]           resp_id,
  output logic [OP_W-1:0]          alu_op,
  output logic [WORD_W-1:0]        alu_a,
  output logic [WORD_W-1:0]        alu_b,
  input  logic [WORD_W-1:0]        alu_out,
  input  logic                     alu_zero,
  input  logic                     alu_error
);

  localparam int IW1 = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e              r_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_owner;
  logic [OP_W-1:0]     r_op;
  logic [WORD_W-1:0]   r_a;
  logic [WORD_W-1:0]   r_b;
  logic [WORD_W-1:0]   r_out;
  logic                r_zero;
  logic                r_err;
  logic [IDW-1:0]      r_id;
  logic [NREQ-1:0]     r_resp_valid;

  logic                w_found;
  logic [IDW-1:0]      w_gnt_id;
  logic [NREQ-1:0]     w_gnt_oh;
  logic [IDW-1:0]      w_next_ptr;
  logic                w_hs;

  // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); first valid wins
  always_comb begin
    logic [IW1-1:0] idx;
    w_found  = 1'b0;
    w_gnt_id = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_rr_ptr} + IW1'(k);
      if (idx >= IW1'(NREQ))
        idx = idx - IW1'(NREQ);
      if (!w_found && req_valid[idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = idx[IDW-1:0];
      end
    end
  end

  assign w_gnt_oh   = w_found ? (NREQ'(1) << w_gnt_id) : '0;
  assign req_ready  = (r_state == S_IDLE) ? w_gnt_oh : '0;
  assign w_hs       = |(req_ready & req_valid);
  assign w_next_ptr = (w_gnt_id == IDW'(NREQ - 1)) ? '0
                    : w_gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_op         <= ALU_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_out        <= '0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
      r_id         <= '0;
      r_resp_valid <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_op     <= req_op[w_gnt_id*OP_W +: OP_W];
            r_a      <= req_a[w_gnt_id*WORD_W +: WORD_W];
            r_b      <= req_b[w_gnt_id*WORD_W +: WORD_W];
            r_owner  <= w_gnt_id;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_out        <= alu_out;
          r_zero       <= alu_zero;
          r_err        <= alu_error;
          r_id         <= r_owner;
          r_resp_valid <= NREQ'(1) << r_owner;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's accept retires the response
          if (resp_ready[r_owner]) begin
            r_resp_valid <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= '0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_out   = r_out;
  assign resp_zero  = r_zero;
  assign resp_error = r_err;
  assign resp_id    = r_id;
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU on the shared port.
// Expected values are hand-computed per vector.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [NREQ*WORD_W-1:0] req_a;
  logic [NREQ*WORD_W-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [WORD_W-1:0]      resp_out;
  logic                   resp_zero;
  logic                   resp_error;
  logic [IDW-1:0]         resp_id;
  logic [OP_W-1:0]        alu_op;
  logic [WORD_W-1:0]      alu_a;
  logic [WORD_W-1:0]      alu_b;
  logic [WORD_W-1:0]      alu_out;
  logic                   alu_zero;
  logic                   alu_error;

  int n_cmp;
  int n_bad;

  alu_scheduler #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_zero  (resp_zero),
    .resp_error (resp_error),
    .resp_id    (resp_id),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_error  (alu_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    alu_out   = '0;
    alu_error = 1'b0;
    case (alu_op)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'd0, alu_a < alu_b};
      ALU_SLL:  alu_out = alu_a << alu_b[4:0];
      ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_out = $signed(alu_a) >>> alu_b[4:0];
      default:  alu_error = 1'b1;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[i*OP_W +: OP_W]     = op;
    req_a[i*WORD_W +: WORD_W]  = a;
    req_b[i*WORD_W +: WORD_W]  = b;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_ready", req_ready, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_out", resp_out, 0);
    chk("rst_zero", resp_zero, 0);
    chk("rst_err", resp_error, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_op", alu_op, ALU_ADD);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);

    // single request: ADD 10,7
    set_req(0, ALU_ADD, 32'd10, 32'd7);
    req_valid  = 2'b01;
    resp_ready = 2'b11;
    #1;
    chk("t1_gnt", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_alu_a", alu_a, 10);
    chk("t1_alu_b", alu_b, 7);
    chk("t1_exec_rv", resp_valid, 0);
    tick();
    chk("t1_rv", resp_valid, 2'b01);
    chk("t1_out", resp_out, 17);
    chk("t1_zero", resp_zero, 0);
    chk("t1_id", resp_id, 0);
    tick();
    chk("t1_idle_rv", resp_valid, 0);

    // contention from rr_ptr=0: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, ALU_SUB, 32'd20, 32'd3);
    set_req(1, ALU_SLT, 32'hFFFF_FFFE, 32'd5);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_gnt", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      tick();
      chk("t2_rv", resp_valid, (g % 2 == 1) ? 2'b10 : 2'b01);
      chk("t2_id", resp_id, g % 2);
      chk("t2_out", resp_out, (g % 2 == 1) ? 1 : 17);
      tick();
    end

    // backpressure with non-owner ready and a pending request
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    #1;
    chk("t3_gnt", req_ready, 2'b01);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      resp_ready = 2'b10;
      #1;
      chk("t3_rv", resp_valid, 2'b01);
      chk("t3_out", resp_out, 3);
      chk("t3_rdy", req_ready, 0);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    chk("t3_rel_rv", resp_valid, 0);
    chk("t3_idle_gnt", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;
    chk("t3_drop", req_ready, 0);
    tick();
    tick();
    chk("t3_nogrant_rv", resp_valid, 0);
    chk("t3_hold_a", alu_a, 1);

    // zero result, then illegal op
    set_req(0, ALU_SUB, 32'd5, 32'd5);
    req_valid  = 2'b01;
    resp_ready = 2'b01;
    #1;
    chk("t4_gnt", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t4_out", resp_out, 0);
    chk("t4_zero", resp_zero, 1);
    chk("t4_err", resp_error, 0);
    tick();
    set_req(1, 4'hF, 32'd1, 32'd2);
    req_valid  = 2'b10;
    resp_ready = 2'b10;
    #1;
    chk("t4b_gnt", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t4b_err", resp_error, 1);
    chk("t4b_rv", resp_valid, 2'b10);
    chk("t4b_id", resp_id, 1);
    tick();
    chk("t4b_done", resp_valid, 0);
    req_valid = 2'b01;
    #1;
    chk("t4b_idle", req_ready, 2'b01);

    // operand change after grant
    set_req(0, ALU_ADD, 32'd100, 32'd1);
    resp_ready = 2'b01;
    tick();
    set_req(0, ALU_SUB, 32'd500, 32'd9);
    req_valid = 2'b00;
    #1;
    chk("t5_alu_a", alu_a, 100);
    chk("t5_alu_op", alu_op, ALU_ADD);
    tick();
    chk("t5_out", resp_out, 101);
    tick();

    // reset while in EXEC
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    set_req(1, ALU_ADD, 32'd8, 32'd8);
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    tick();
    reset     = 1'b1;
    req_valid = 2'b11;
    tick();
    reset = 1'b0;
    #1;
    chk("t6a_rv", resp_valid, 0);
    chk("t6a_out", resp_out, 0);
    chk("t6a_a", alu_a, 0);
    chk("t6a_op", alu_op, ALU_ADD);
    chk("t6a_gnt", req_ready, 2'b01);

    // reset while in RESP
    tick();
    tick();
    chk("t6b_pre_rv", resp_valid, 2'b01);
    chk("t6b_pre_out", resp_out, 7);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("t6b_rv", resp_valid, 0);
    chk("t6b_out", resp_out, 0);
    chk("t6b_id", resp_id, 0);
    chk("t6b_zero", resp_zero, 0);
    chk("t6b_err", resp_error, 0);
    req_valid = 2'b11;
    #1;
    chk("t6b_gnt", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    tick();
    chk("t6b_idle_rv", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
